// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding and sizing constants.
package intr_pkg;
  localparam int NUM_SRC_MAX = 16;
  localparam int VEC_STRIDE  = 4;
  localparam int ID_W        = $clog2(NUM_SRC_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } intr_state_t;
endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: reports whether any bit is set and the lowest set index.
module intr_prio_enc
  import intr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] vec,
  output logic             valid,
  output logic [ID_W-1:0]  index
);

  always_comb begin
    valid = |vec;
    index = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) index = ID_W'(i);
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Level-edge interrupt controller with fixed-priority arbitration and vectoring.
// Optional one-level preemption is compiled in when INTR_NEST_EN is defined.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int NUM_SRC    = 8,
  parameter int VEC_STRIDE = intr_pkg::VEC_STRIDE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic               mask_we_i,
  input  logic [NUM_SRC-1:0] mask_wdata_i,
  input  logic               gie_i,
  input  logic [31:0]        vec_base_i,
  input  logic               irq_ack_i,
  input  logic               irq_ret_i,
  output logic               irq_req_o,
  output logic [3:0]         irq_id_o,
  output logic [31:0]        irq_vec_o,
  output logic               irq_active_o,
  output logic [NUM_SRC-1:0] pending_o
);

  intr_state_t        state_reg, state_next;
  logic [ID_W-1:0]    id_reg, id_next;
  logic [NUM_SRC-1:0] pending_reg, mask_reg, irq_prev_reg;
  logic [NUM_SRC-1:0] rise, enabled, id_onehot, clr_mask;
  logic               enc_valid, id_enabled, ack_fire;
  logic [ID_W-1:0]    enc_index, ack_id, id_out;
  logic               req_out;

  assign rise    = irq_i & ~irq_prev_reg;
  assign enabled = pending_reg & mask_reg;

  intr_prio_enc #(.WIDTH(NUM_SRC)) u_prio_enc (
    .vec   (enabled),
    .valid (enc_valid),
    .index (enc_index)
  );

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign id_onehot[gi] = (id_reg == ID_W'(gi));
      assign clr_mask[gi]  = ack_fire && (ack_id == ID_W'(gi));
    end
  endgenerate

  assign id_enabled = |(id_onehot & mask_reg);

`ifdef INTR_NEST_EN
  logic               pre_req_reg, pre_req_next;
  logic [ID_W-1:0]    pre_id_reg, pre_id_next;
  logic [ID_W-1:0]    save_reg, save_next;
  logic               nested_reg, nested_next;
  logic [NUM_SRC-1:0] pre_onehot;
  logic               pre_enabled;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pre
      assign pre_onehot[gi] = (pre_id_reg == ID_W'(gi));
    end
  endgenerate

  assign pre_enabled = |(pre_onehot & mask_reg);
  assign req_out     = (state_reg == REQ) || pre_req_reg;
  assign id_out      = pre_req_reg ? pre_id_reg : id_reg;
`else
  assign req_out = (state_reg == REQ);
  assign id_out  = id_reg;
`endif

  always_comb begin
    state_next = state_reg;
    id_next    = id_reg;
    ack_fire   = 1'b0;
    ack_id     = id_reg;
`ifdef INTR_NEST_EN
    pre_req_next = pre_req_reg;
    pre_id_next  = pre_id_reg;
    save_next    = save_reg;
    nested_next  = nested_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (gie_i && enc_valid) begin
          state_next = REQ;
          id_next    = enc_index;
        end
      end
      REQ: begin
        // An accepted request takes precedence over a same-cycle abort.
        if (irq_ack_i) begin
          ack_fire   = 1'b1;
          state_next = ACTIVE;
        end else if (!gie_i || !id_enabled) begin
          state_next = IDLE;
        end
      end
      ACTIVE: begin
`ifdef INTR_NEST_EN
        if (irq_ret_i) begin
          pre_req_next = 1'b0;
          if (nested_reg) begin
            id_next     = save_reg;
            nested_next = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end else if (pre_req_reg) begin
          if (irq_ack_i) begin
            ack_fire     = 1'b1;
            ack_id       = pre_id_reg;
            save_next    = id_reg;
            id_next      = pre_id_reg;
            nested_next  = 1'b1;
            pre_req_next = 1'b0;
          end else if (!gie_i || !pre_enabled) begin
            pre_req_next = 1'b0;
          end
        end else if (!nested_reg && gie_i && enc_valid && (enc_index < id_reg)) begin
          pre_req_next = 1'b1;
          pre_id_next  = enc_index;
        end
`else
        if (irq_ret_i) state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      id_reg       <= '0;
      pending_reg  <= '0;
      mask_reg     <= '0;
      irq_prev_reg <= '0;
`ifdef INTR_NEST_EN
      pre_req_reg  <= 1'b0;
      pre_id_reg   <= '0;
      save_reg     <= '0;
      nested_reg   <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      id_reg       <= id_next;
      // A fresh edge on the acknowledged source keeps its pending bit set.
      pending_reg  <= (pending_reg & ~clr_mask) | rise;
      irq_prev_reg <= irq_i;
      if (mask_we_i) mask_reg <= mask_wdata_i;
`ifdef INTR_NEST_EN
      pre_req_reg  <= pre_req_next;
      pre_id_reg   <= pre_id_next;
      save_reg     <= save_next;
      nested_reg   <= nested_next;
`endif
    end
  end

  assign irq_req_o    = req_out;
  assign irq_id_o     = id_out;
  assign irq_vec_o    = vec_base_i + ({{(32 - ID_W){1'b0}}, id_out} * 32'(VEC_STRIDE));
  assign irq_active_o = (state_reg == ACTIVE);
  assign pending_o    = pending_reg;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: expected requests are queued as stimulus is applied
// and popped when the controller raises irq_req_o.
module tb_intr_ctrl;

  localparam int NUM_SRC    = 8;
  localparam int VEC_STRIDE = 4;
  localparam logic [31:0] BASE = 32'h100;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NUM_SRC-1:0] irq_i = '0;
  logic               mask_we_i = 1'b0;
  logic [NUM_SRC-1:0] mask_wdata_i = '0;
  logic               gie_i = 1'b0;
  logic [31:0]        vec_base_i = BASE;
  logic               irq_ack_i = 1'b0;
  logic               irq_ret_i = 1'b0;
  logic               irq_req_o;
  logic [3:0]         irq_id_o;
  logic [31:0]        irq_vec_o;
  logic               irq_active_o;
  logic [NUM_SRC-1:0] pending_o;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] vec;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  intr_ctrl #(.NUM_SRC(NUM_SRC), .VEC_STRIDE(VEC_STRIDE)) dut (
    .clk          (clk),
    .rst          (rst),
    .irq_i        (irq_i),
    .mask_we_i    (mask_we_i),
    .mask_wdata_i (mask_wdata_i),
    .gie_i        (gie_i),
    .vec_base_i   (vec_base_i),
    .irq_ack_i    (irq_ack_i),
    .irq_ret_i    (irq_ret_i),
    .irq_req_o    (irq_req_o),
    .irq_id_o     (irq_id_o),
    .irq_vec_o    (irq_vec_o),
    .irq_active_o (irq_active_o),
    .pending_o    (pending_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input int id);
    exp_t e;
    e.id  = 4'(id);
    e.vec = BASE + 32'(id * VEC_STRIDE);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      if (irq_req_o === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic write_mask(input logic [NUM_SRC-1:0] m);
    mask_we_i = 1'b1; mask_wdata_i = m; tick(); mask_we_i = 1'b0;
  endtask

  task automatic ack_cycle();
    irq_ack_i = 1'b1; tick(); irq_ack_i = 1'b0;
  endtask

  task automatic ret_cycle();
    irq_ret_i = 1'b1; tick(); irq_ret_i = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    total_cnt++; if (irq_req_o !== 1'b0) $display("FAIL rst_req: got %0b want 0", irq_req_o); else pass_cnt++;
    total_cnt++; if (irq_active_o !== 1'b0) $display("FAIL rst_active: got %0b want 0", irq_active_o); else pass_cnt++;
    total_cnt++; if (irq_id_o !== 4'd0) $display("FAIL rst_id: got %0d want 0", irq_id_o); else pass_cnt++;
    total_cnt++; if (pending_o !== 8'h00) $display("FAIL rst_pending: got %0h want 0", pending_o); else pass_cnt++;
    total_cnt++; if (irq_vec_o !== BASE) $display("FAIL rst_vec: got %0h want %0h", irq_vec_o, BASE); else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++; if (pending_o !== 8'h00) $display("FAIL post_rst_pending: got %0h want 0", pending_o); else pass_cnt++;
    $display("reset: done");
  endtask

  task automatic test_single();
    exp_t e;
    bit   ok;
    write_mask(8'hFF);
    gie_i = 1'b1;
    sb.push_back(mk(3));
    irq_i[3] = 1'b1;
    tick();
    total_cnt++; if (pending_o[3] !== 1'b1) $display("FAIL single_pend: got %0b want 1", pending_o[3]); else pass_cnt++;
    total_cnt++; if (irq_req_o !== 1'b0) $display("FAIL single_early_req: got %0b want 0", irq_req_o); else pass_cnt++;
    tick();
    ok = irq_req_o === 1'b1;
    e = sb.pop_front();
    total_cnt++; if (ok !== 1'b1) $display("FAIL single_req: got %0b want 1", irq_req_o); else pass_cnt++;
    total_cnt++; if (irq_id_o !== e.id) $display("FAIL single_id: got %0d want %0d", irq_id_o, e.id); else pass_cnt++;
    total_cnt++; if (irq_vec_o !== e.vec) $display("FAIL single_vec: got %0h want %0h", irq_vec_o, e.vec); else pass_cnt++;
    ack_cycle();
    irq_i[3] = 1'b0;
    total_cnt++; if (irq_req_o !== 1'b0) $display("FAIL single_ack_req: got %0b want 0", irq_req_o); else pass_cnt++;
    total_cnt++; if (irq_active_o !== 1'b1) $display("FAIL single_active: got %0b want 1", irq_active_o); else pass_cnt++;
    total_cnt++; if (pending_o[3] !== 1'b0) $display("FAIL single_clr: got %0b want 0", pending_o[3]); else pass_cnt++;
    ret_cycle();
    total_cnt++; if (irq_active_o !== 1'b0) $display("FAIL single_ret_active: got %0b want 0", irq_active_o); else pass_cnt++;
    total_cnt++; if (irq_req_o !== 1'b0) $display("FAIL single_ret_req: got %0b want 0", irq_req_o); else pass_cnt++;
    $display("single: id=%0d vec=%0h", e.id, e.vec);
  endtask

  task automatic test_priority();
    exp_t e;
    bit   ok;
    sb.push_back(mk(2));
    sb.push_back(mk(5));
    irq_i[5] = 1'b1; irq_i[2] = 1'b1;
    tick();
    wait_req(ok);
    e = sb.pop_front();
    total_cnt++; if (ok !== 1'b1) $display("FAIL prio_req1: got %0b want 1", irq_req_o); else pass_cnt++;
    total_cnt++; if (irq_id_o !== e.id) $display("FAIL prio_id1: got %0d want %0d", irq_id_o, e.id); else pass_cnt++;
    ack_cycle();
    total_cnt++; if (pending_o[5] !== 1'b1) $display("FAIL prio_pend5: got %0b want 1", pending_o[5]); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++; if (irq_req_o !== 1'b0) $display("FAIL prio_hold_req: got %0b want 0", irq_req_o); else pass_cnt++;
    end
    ret_cycle();
    total_cnt++; if (irq_req_o !== 1'b0) $display("FAIL prio_rearb_early: got %0b want 0", irq_req_o); else pass_cnt++;
    wait_req(ok);
    e = sb.pop_front();
    total_cnt++; if (ok !== 1'b1) $display("FAIL prio_req2: got %0b want 1", irq_req_o); else pass_cnt++;
    total_cnt++; if (irq_id_o !== e.id) $display("FAIL prio_id2: got %0d want %0d", irq_id_o, e.id); else pass_cnt++;
    total_cnt++; if (irq_vec_o !== e.vec) $display("FAIL prio_vec2: got %0h want %0h", irq_vec_o, e.vec); else pass_cnt++;
    ack_cycle();
    ret_cycle();
    irq_i = '0;
    tick();
    $display("priority: second id=%0d", e.id);
  endtask

  task automatic test_mask();
    exp_t e;
    write_mask(8'h00);
    irq_i[1] = 1'b1;
    tick(); tick(); tick();
    total_cnt++; if (irq_req_o !== 1'b0) $display("FAIL mask_noreq: got %0b want 0", irq_req_o); else pass_cnt++;
    total_cnt++; if (pending_o[1] !== 1'b1) $display("FAIL mask_pend: got %0b want 1", pending_o[1]); else pass_cnt++;
    sb.push_back(mk(1));
    write_mask(8'h02);
    total_cnt++; if (irq_req_o !== 1'b0) $display("FAIL mask_oldmask: got %0b want 0", irq_req_o); else pass_cnt++;
    tick();
    e = sb.pop_front();
    total_cnt++; if (irq_req_o !== 1'b1) $display("FAIL mask_req: got %0b want 1", irq_req_o); else pass_cnt++;
    total_cnt++; if (irq_id_o !== e.id) $display("FAIL mask_id: got %0d want %0d", irq_id_o, e.id); else pass_cnt++;
    ack_cycle();
    ret_cycle();
    irq_i = '0;
    tick();
    $display("mask: id=%0d", e.id);
  endtask

  task automatic test_abort();
    exp_t e;
    bit   ok;
    write_mask(8'hFF);
    sb.push_back(mk(6));
    irq_i[6] = 1'b1;
    tick();
    wait_req(ok);
    e = sb.pop_front();
    total_cnt++; if (ok !== 1'b1) $display("FAIL abort_req1: got %0b want 1", irq_req_o); else pass_cnt++;
    total_cnt++; if (irq_id_o !== e.id) $display("FAIL abort_id1: got %0d want %0d", irq_id_o, e.id); else pass_cnt++;
    gie_i = 1'b0;
    tick();
    total_cnt++; if (irq_req_o !== 1'b0) $display("FAIL abort_drop: got %0b want 0", irq_req_o); else pass_cnt++;
    total_cnt++; if (pending_o[6] !== 1'b1) $display("FAIL abort_pend: got %0b want 1", pending_o[6]); else pass_cnt++;
    ack_cycle();
    total_cnt++; if (pending_o[6] !== 1'b1) $display("FAIL abort_stray_ack: got %0b want 1", pending_o[6]); else pass_cnt++;
    total_cnt++; if (irq_active_o !== 1'b0) $display("FAIL abort_active: got %0b want 0", irq_active_o); else pass_cnt++;
    sb.push_back(mk(6));
    gie_i = 1'b1;
    wait_req(ok);
    e = sb.pop_front();
    total_cnt++; if (ok !== 1'b1) $display("FAIL abort_reissue: got %0b want 1", irq_req_o); else pass_cnt++;
    total_cnt++; if (irq_vec_o !== e.vec) $display("FAIL abort_vec: got %0h want %0h", irq_vec_o, e.vec); else pass_cnt++;
    ack_cycle();
    ret_cycle();
    irq_i = '0;
    tick();
    $display("abort: reissued id=%0d", e.id);
  endtask

  task automatic test_ack_edge();
    exp_t e;
    bit   ok;
    sb.push_back(mk(7));
    irq_i[7] = 1'b1;
    tick();
    irq_i[7] = 1'b0;
    wait_req(ok);
    e = sb.pop_front();
    total_cnt++; if (ok !== 1'b1) $display("FAIL ackedge_req: got %0b want 1", irq_req_o); else pass_cnt++;
    total_cnt++; if (irq_id_o !== e.id) $display("FAIL ackedge_id: got %0d want %0d", irq_id_o, e.id); else pass_cnt++;
    irq_i[7] = 1'b1;
    ack_cycle();
    irq_i[7] = 1'b0;
    total_cnt++; if (pending_o[7] !== 1'b1) $display("FAIL ackedge_keep: got %0b want 1", pending_o[7]); else pass_cnt++;
    total_cnt++; if (irq_active_o !== 1'b1) $display("FAIL ackedge_active: got %0b want 1", irq_active_o); else pass_cnt++;
    sb.push_back(mk(7));
    ret_cycle();
    wait_req(ok);
    e = sb.pop_front();
    total_cnt++; if (ok !== 1'b1) $display("FAIL ackedge_req2: got %0b want 1", irq_req_o); else pass_cnt++;
    total_cnt++; if (irq_id_o !== e.id) $display("FAIL ackedge_id2: got %0d want %0d", irq_id_o, e.id); else pass_cnt++;
    ack_cycle();
    total_cnt++; if (pending_o[7] !== 1'b0) $display("FAIL ackedge_clr: got %0b want 0", pending_o[7]); else pass_cnt++;
    ret_cycle();
    $display("ack_edge: id=%0d re-requested", e.id);
  endtask

`ifdef INTR_NEST_EN
  task automatic test_nest();
    exp_t e;
    bit   ok;
    sb.push_back(mk(4));
    irq_i[4] = 1'b1;
    tick();
    wait_req(ok);
    e = sb.pop_front();
    total_cnt++; if (irq_id_o !== e.id) $display("FAIL nest_id4: got %0d want %0d", irq_id_o, e.id); else pass_cnt++;
    ack_cycle();
    sb.push_back(mk(0));
    irq_i[0] = 1'b1;
    tick();
    wait_req(ok);
    e = sb.pop_front();
    total_cnt++; if (ok !== 1'b1) $display("FAIL nest_req0: got %0b want 1", irq_req_o); else pass_cnt++;
    total_cnt++; if (irq_id_o !== e.id) $display("FAIL nest_id0: got %0d want %0d", irq_id_o, e.id); else pass_cnt++;
    total_cnt++; if (irq_vec_o !== e.vec) $display("FAIL nest_vec0: got %0h want %0h", irq_vec_o, e.vec); else pass_cnt++;
    ack_cycle();
    total_cnt++; if (irq_active_o !== 1'b1) $display("FAIL nest_active: got %0b want 1", irq_active_o); else pass_cnt++;
    total_cnt++; if (irq_req_o !== 1'b0) $display("FAIL nest_ack_req: got %0b want 0", irq_req_o); else pass_cnt++;
    ret_cycle();
    total_cnt++; if (irq_id_o !== 4'd4) $display("FAIL nest_restore: got %0d want 4", irq_id_o); else pass_cnt++;
    total_cnt++; if (irq_active_o !== 1'b1) $display("FAIL nest_still_active: got %0b want 1", irq_active_o); else pass_cnt++;
    ret_cycle();
    total_cnt++; if (irq_active_o !== 1'b0) $display("FAIL nest_idle: got %0b want 0", irq_active_o); else pass_cnt++;
    irq_i = '0;
    tick();
    $display("nest: restored id=4 then idle");
  endtask
`else
  task automatic test_no_preempt();
    exp_t e;
    bit   ok;
    sb.push_back(mk(4));
    irq_i[4] = 1'b1;
    tick();
    wait_req(ok);
    e = sb.pop_front();
    total_cnt++; if (irq_id_o !== e.id) $display("FAIL nopre_id4: got %0d want %0d", irq_id_o, e.id); else pass_cnt++;
    ack_cycle();
    irq_i[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++; if (irq_req_o !== 1'b0) $display("FAIL nopre_req: got %0b want 0", irq_req_o); else pass_cnt++;
    end
    total_cnt++; if (irq_id_o !== 4'd4) $display("FAIL nopre_id_hold: got %0d want 4", irq_id_o); else pass_cnt++;
    sb.push_back(mk(0));
    ret_cycle();
    wait_req(ok);
    e = sb.pop_front();
    total_cnt++; if (ok !== 1'b1) $display("FAIL nopre_req0: got %0b want 1", irq_req_o); else pass_cnt++;
    total_cnt++; if (irq_vec_o !== e.vec) $display("FAIL nopre_vec0: got %0h want %0h", irq_vec_o, e.vec); else pass_cnt++;
    ack_cycle();
    ret_cycle();
    irq_i = '0;
    tick();
    $display("no_preempt: id=%0d served after ret", e.id);
  endtask
`endif

  task automatic test_reset_active();
    exp_t e;
    bit   ok;
    sb.push_back(mk(3));
    irq_i[3] = 1'b1;
    tick();
    wait_req(ok);
    e = sb.pop_front();
    total_cnt++; if (irq_id_o !== e.id) $display("FAIL rsta_id: got %0d want %0d", irq_id_o, e.id); else pass_cnt++;
    ack_cycle();
    irq_i[4] = 1'b1;
    tick(); tick();
    total_cnt++; if (pending_o[4] !== 1'b1) $display("FAIL rsta_pend4: got %0b want 1", pending_o[4]); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (irq_active_o !== 1'b0) $display("FAIL rsta_active: got %0b want 0", irq_active_o); else pass_cnt++;
    total_cnt++; if (irq_req_o !== 1'b0) $display("FAIL rsta_req: got %0b want 0", irq_req_o); else pass_cnt++;
    total_cnt++; if (irq_id_o !== 4'd0) $display("FAIL rsta_id0: got %0d want 0", irq_id_o); else pass_cnt++;
    total_cnt++; if (pending_o !== 8'h00) $display("FAIL rsta_pend: got %0h want 0", pending_o); else pass_cnt++;
    total_cnt++; if (irq_vec_o !== BASE) $display("FAIL rsta_vec: got %0h want %0h", irq_vec_o, BASE); else pass_cnt++;
    irq_i = '0;
    tick();
    rst = 1'b0;
    irq_i[2] = 1'b1;
    tick(); tick(); tick();
    total_cnt++; if (irq_req_o !== 1'b0) $display("FAIL rsta_maskclr: got %0b want 0", irq_req_o); else pass_cnt++;
    total_cnt++; if (pending_o !== 8'h04) $display("FAIL rsta_newpend: got %0h want 4", pending_o); else pass_cnt++;
    $display("reset_active: state discarded");
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_abort();
    test_ack_edge();
`ifdef INTR_NEST_EN
    test_nest();
`else
    test_no_preempt();
`endif
    test_reset_active();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 8, giving the number of interrupt sources (range 2..16).
REQ-002 The block SHALL have parameter VEC_STRIDE, default 4, giving the byte spacing between vector entries.
REQ-003 The clock and reset SHALL be as follows: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 irq_i  input  NUM_SRC  level interrupt lines, already synchronous to clk.
REQ-007 mask_we_i  input  1  write strobe for the enable mask.
REQ-008 mask_wdata_i  input  NUM_SRC  new enable mask value.
REQ-009 gie_i  input  1  global interrupt enable from the core.
REQ-010 vec_base_i  input  32  vector table base address.
REQ-011 irq_ack_i  input  1  the core accepts the current request.
REQ-012 irq_ret_i  input  1  mret retired.
REQ-013 irq_req_o  output  1  interrupt request to the pipeline.
REQ-014 irq_id_o  output  4  index of the requested source.
REQ-015 irq_vec_o  output  32  handler address, equal to vec_base_i + irq_id_o*VEC_STRIDE, mod 2^32.
REQ-016 irq_active_o  output  1  a handler is in progress.
REQ-017 pending_o  output  NUM_SRC  pending register, for CSR read.

Function
REQ-018 Pending bit k SHALL set on the cycle after a 0->1 edge of irq_i[k]; a bit that is already pending SHALL ignore further edges.
REQ-019 The arbiter SHALL be fixed-priority: the lowest enabled pending index wins.
REQ-020 The FSM SHALL have three states: IDLE, REQ and ACTIVE.
REQ-021 IDLE -> REQ: taken when gie_i is high and (pending & mask) is nonzero; irq_req_o SHALL assert the next cycle, with irq_id_o latched.
REQ-022 REQ behaviour:
- irq_id_o and irq_vec_o SHALL be held stable until acknowledge.
- irq_ack_i SHALL clear pending[id] and move the FSM to ACTIVE.
- irq_req_o SHALL drop in the same cycle irq_ack_i is sampled.
REQ-023 REQ -> IDLE without acknowledge: if gie_i falls, or the latched source becomes masked, before irq_ack_i, the FSM SHALL return to IDLE and irq_req_o SHALL deassert; pending SHALL be unchanged.
REQ-024 ACTIVE behaviour: irq_active_o=1; irq_ret_i SHALL move the FSM to IDLE, and re-arbitration SHALL occur no earlier than the following cycle.
REQ-025 A same-source edge arriving in the acknowledge cycle SHALL win: the pending bit stays set.
REQ-026 When mask_we_i coincides with arbitration, the old mask SHALL be used that cycle; the new mask SHALL take effect the next cycle.
REQ-027 irq_ack_i and irq_ret_i SHALL be ignored in states where they are not expected.

Reset
REQ-028 Reset SHALL force the following, asynchronously:
- FSM to IDLE.
- irq_req_o=0, irq_active_o=0, irq_id_o=0.
- pending and mask all zero.
- edge-detect history all zero.
REQ-029 irq_vec_o SHALL equal vec_base_i during reset.
REQ-030 Reset asserted mid-REQ or mid-ACTIVE SHALL discard all in-flight state.

Configuration
REQ-031 With INTR_NEST_EN defined, the block SHALL support one level of preemption:
- In ACTIVE, a pending source with index lower than the active id SHALL raise irq_req_o again.
- Its acknowledge SHALL push the active id into a depth-1 save register; the FSM stays in ACTIVE.
- The first irq_ret_i SHALL restore the saved id; the second irq_ret_i SHALL return the FSM to IDLE.
- A further preemption while nested SHALL be blocked.
REQ-032 Without INTR_NEST_EN, the block SHALL never raise irq_req_o in ACTIVE, and no save register SHALL exist.

Structure
REQ-033 The FSM state encoding and the constants NUM_SRC_MAX=16 and VEC_STRIDE SHALL live in shared package intr_pkg.
REQ-034 The priority encoder SHALL be the sub-module intr_prio_enc (inputs: vector; outputs: valid, index).

Verification
REQ-035 Single request: mask=0xFF, gie=1, irq_i[3] rising edge, vec_base=0x100. Required: irq_req_o=1 with id=3 and vec=0x10C; after ack, pending[3]=0 and active=1; after ret, the FSM is IDLE.
REQ-036 Priority: simultaneous edges on sources 5 and 2. Required: id=2 first; source 5 requested only after the first ret.
REQ-037 Masking: edge on source 1 with mask=0x00. Required: no request, pending[1]=1; after writing mask=0x02, request with id=1 the following cycle.
REQ-038 Abort: gie falls while in REQ. Required: irq_req_o drops, pending is kept, and the request re-issues when gie rises.
REQ-039 Reset: rst asserted while in ACTIVE. Required: all outputs 0 immediately and pending cleared.
REQ-040 Nesting (INTR_NEST_EN only): source 4 is active when an edge arrives on source 0. Required: request with id=0; ret restores id=4; a second ret returns to IDLE.
